// File: rtl/merge_runs_if.sv
// merge_runs_if: run FIFOs, output FIFO and control bundle for merge_runs.
// out_src is present only when MERGE_RUNS_SRC_TAG_EN is defined.
interface merge_runs_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 2
);
    logic              start;
    logic [CNT_W-1:0]  len_l;
    logic [CNT_W-1:0]  len_r;
    logic [DATA_W-1:0] l_data;
    logic              l_empty;
    logic              l_rd;
    logic [DATA_W-1:0] r_data;
    logic              r_empty;
    logic              r_rd;
    logic [DATA_W-1:0] out_data;
    logic              out_wr;
    logic              out_full;
    logic              busy;
    logic              done;
`ifdef MERGE_RUNS_SRC_TAG_EN
    logic              out_src;
`endif

    modport master (
        output start, len_l, len_r,
        output l_data, l_empty,
        output r_data, r_empty,
        output out_full,
        input  l_rd, r_rd,
        input  out_data, out_wr,
        input  busy, done
`ifdef MERGE_RUNS_SRC_TAG_EN
        , input out_src
`endif
    );

    modport slave (
        input  start, len_l, len_r,
        input  l_data, l_empty,
        input  r_data, r_empty,
        input  out_full,
        output l_rd, r_rd,
        output out_data, out_wr,
        output busy, done
`ifdef MERGE_RUNS_SRC_TAG_EN
        , output out_src
`endif
    );
endinterface

// File: rtl/merge_runs.sv
// merge_runs: streaming two-way merge of two sorted FWFT runs into one FIFO.
// Define MERGE_RUNS_SRC_TAG_EN to add the registered out_src origin tag.
module merge_runs #(
    parameter int DATA_W  = 8,
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = $clog2(RUN_LEN + 1),
    parameter bit DESCEND = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    merge_runs_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        MERGE,
        DRAIN_L,
        DRAIN_R,
        DONE
    } state_e;

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  rem_l_q, rem_l_d;
    logic [CNT_W-1:0]  rem_r_q, rem_r_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_wr_q, out_wr_d;
`ifdef MERGE_RUNS_SRC_TAG_EN
    logic              out_src_q, out_src_d;
`endif

    logic              accept;
    logic              sel_l;
    logic              take_l, take_r;
    logic              l_nz, r_nz;
    logic [CNT_W-1:0]  len_l_c, len_r_c;

    assign accept  = (state_q == IDLE) && bus.start;
    assign len_l_c = (bus.len_l > MAX_LEN) ? MAX_LEN : bus.len_l;
    assign len_r_c = (bus.len_r > MAX_LEN) ? MAX_LEN : bus.len_r;
    assign l_nz    = (len_l_c != '0);
    assign r_nz    = (len_r_c != '0);

    // Ties favour the left run so equal keys keep their input order.
    assign sel_l = DESCEND ? (bus.l_data >= bus.r_data)
                           : (bus.l_data <= bus.r_data);

    always_comb begin
        take_l = 1'b0;
        take_r = 1'b0;
        case (state_q)
            MERGE: begin
                if (!bus.l_empty && !bus.r_empty && !bus.out_full) begin
                    take_l = sel_l;
                    take_r = !sel_l;
                end
            end
            DRAIN_L: take_l = !bus.l_empty && !bus.out_full;
            DRAIN_R: take_r = !bus.r_empty && !bus.out_full;
            default: begin
                take_l = 1'b0;
                take_r = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    unique case (1'b1)
                        (l_nz && r_nz):  state_d = MERGE;
                        (l_nz && !r_nz): state_d = DRAIN_L;
                        (!l_nz && r_nz): state_d = DRAIN_R;
                        default:         state_d = DONE;
                    endcase
                end
            end
            MERGE: begin
                if (take_l && rem_l_q == ONE) begin
                    state_d = DRAIN_R;
                end else if (take_r && rem_r_q == ONE) begin
                    state_d = DRAIN_L;
                end
            end
            DRAIN_L: begin
                if (take_l && rem_l_q == ONE) begin
                    state_d = DONE;
                end
            end
            DRAIN_R: begin
                if (take_r && rem_r_q == ONE) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rem_l_d = rem_l_q;
        rem_r_d = rem_r_q;
        if (accept) begin
            rem_l_d = len_l_c;
            rem_r_d = len_r_c;
        end else begin
            if (take_l) begin
                rem_l_d = rem_l_q - ONE;
            end
            if (take_r) begin
                rem_r_d = rem_r_q - ONE;
            end
        end
        out_wr_d   = take_l || take_r;
        out_data_d = out_data_q;
        if (take_l) begin
            out_data_d = bus.l_data;
        end else if (take_r) begin
            out_data_d = bus.r_data;
        end
    end

`ifdef MERGE_RUNS_SRC_TAG_EN
    always_comb begin
        out_src_d = out_src_q;
        if (take_l) begin
            out_src_d = 1'b0;
        end else if (take_r) begin
            out_src_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_src_q <= 1'b0;
        end else begin
            out_src_q <= out_src_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_l_q    <= '0;
            rem_r_q    <= '0;
            out_data_q <= '0;
            out_wr_q   <= 1'b0;
        end else begin
            rem_l_q    <= rem_l_d;
            rem_r_q    <= rem_r_d;
            out_data_q <= out_data_d;
            out_wr_q   <= out_wr_d;
        end
    end

    always_comb begin
        bus.l_rd     = take_l;
        bus.r_rd     = take_r;
        bus.out_data = out_data_q;
        bus.out_wr   = out_wr_q;
        bus.busy     = (state_q == MERGE) || (state_q == DRAIN_L)
                    || (state_q == DRAIN_R);
        bus.done     = (state_q == DONE);
`ifdef MERGE_RUNS_SRC_TAG_EN
        bus.out_src  = out_src_q;
`endif
    end

    a_one_pop: assert property (
        @(posedge clk) disable iff (rst) !(take_l && take_r));
    a_pop_l_live: assert property (
        @(posedge clk) disable iff (rst) take_l |-> (rem_l_q != '0));
    a_pop_r_live: assert property (
        @(posedge clk) disable iff (rst) take_r |-> (rem_r_q != '0));

endmodule
